// File: rtl/soc_toggle_pkg.sv
// Shared definitions for the converter-paced toggle generator: fetch-state
// encoding and default parameter values.
package soc_toggle_pkg;

    localparam int W_DEFAULT    = 8;
    localparam int INIT_DEFAULT = 10;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_CONV = 2'd1,
        F_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/soc_eoc_fetch.sv
// SOC/EOC handshake with the external converter. Holds a one-entry sample buffer
// that the interval counter drains through consume_i.
//
// state  | meaning
// F_REQ  | soc high, waiting for the converter to drop eoc
// F_CONV | conversion running, waiting for eoc to rise; sample captured then
// F_HOLD | sample buffered, waiting for it to be consumed
module soc_eoc_fetch
    import soc_toggle_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         eoc_i,
    input  logic [W-1:0] numero_i,
    input  logic         consume_i,
    output logic         soc_o,
    output logic         buf_full_o,
    output logic [W-1:0] buf_data_o
);

    fetch_state_e state_q, state_d;
    logic         soc_q, soc_d;
    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= F_REQ;
            soc_q   <= 1'b0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            soc_q   <= soc_d;
            full_q  <= full_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        data_d  = data_q;

        if (consume_i) begin
            full_d = 1'b0;
        end

        case (state_q)
            // Only leave F_REQ once soc is actually on the wire, so an eoc that
            // is already low at reset release is not taken as an acknowledge.
            F_REQ: begin
                if (soc_q && !eoc_i) begin
                    state_d = F_CONV;
                end
            end
            F_CONV: begin
                if (eoc_i) begin
                    data_d  = numero_i;
                    full_d  = 1'b1;
                    state_d = F_HOLD;
                end
            end
            F_HOLD: begin
                if (!full_q) begin
                    state_d = F_REQ;
                end
            end
            default: begin
                state_d = F_REQ;
            end
        endcase

        soc_d = (state_d == F_REQ);
    end

    assign soc_o      = soc_q;
    assign buf_full_o = full_q;
    assign buf_data_o = data_q;

endmodule

// File: rtl/soc_toggle_gen.sv
// Square-wave generator whose half-periods come from successive converter samples;
// a down-counter expires at 1 and reloads from the fetch buffer.
module soc_toggle_gen
    import soc_toggle_pkg::*;
#(
    parameter int W    = W_DEFAULT,
    parameter int INIT = INIT_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    output logic         soc,
    input  logic         eoc,
    input  logic [W-1:0] numero,
    output logic         out,
    output logic         underrun
);

    localparam logic [W:0] INIT_CNT = (W+1)'(INIT);
    localparam logic [W:0] CNT_ONE  = (W+1)'(1);
    localparam logic [W:0] CNT_FULL = {1'b1, {W{1'b0}}};

    logic         buf_full;
    logic [W-1:0] buf_data;
    logic         consume;

    logic [W:0]   count_q, count_d;
    logic         out_q, out_d;
    logic         underrun_q, underrun_d;

    soc_eoc_fetch #(
        .W (W)
    ) u_fetch (
        .clock      (clock),
        .reset      (reset),
        .eoc_i      (eoc),
        .numero_i   (numero),
        .consume_i  (consume),
        .soc_o      (soc),
        .buf_full_o (buf_full),
        .buf_data_o (buf_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= INIT_CNT;
            out_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            out_q      <= out_d;
            underrun_q <= underrun_d;
        end
    end

    // Terminal count is 1, not 0: the counter parks at 1 while starved and the
    // toggle fires on the first edge that sees a buffered sample.
    always_comb begin
        count_d    = count_q;
        out_d      = out_q;
        underrun_d = underrun_q;
        consume    = 1'b0;

        if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
        end else if (buf_full) begin
            consume = 1'b1;
            out_d   = ~out_q;
            count_d = (buf_data == '0) ? CNT_FULL : {1'b0, buf_data};
        end else begin
            underrun_d = 1'b1;
        end
    end

    assign out      = out_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_soc_toggle_gen.sv
// Directed bench for soc_toggle_gen: three parameterisations driven by a
// converter model, checked at hand-computed edge numbers after reset release.
module tb_soc_toggle_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] numero_a, numero_c;
    logic [3:0] numero_b;
    logic [2:0] soc_v, eoc_v, out_v, und_v;
    logic [2:0] idle_lvl;
    logic [2:0] busy_m;
    int         tmr_m [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cur   = 0;

    always #5 clock = ~clock;

    soc_toggle_gen #(.W(8), .INIT(10)) u_dut_a (
        .clock (clock), .reset (reset), .soc (soc_v[0]), .eoc (eoc_v[0]),
        .numero (numero_a), .out (out_v[0]), .underrun (und_v[0])
    );

    soc_toggle_gen #(.W(4), .INIT(10)) u_dut_b (
        .clock (clock), .reset (reset), .soc (soc_v[1]), .eoc (eoc_v[1]),
        .numero (numero_b), .out (out_v[1]), .underrun (und_v[1])
    );

    soc_toggle_gen #(.W(8), .INIT(1)) u_dut_c (
        .clock (clock), .reset (reset), .soc (soc_v[2]), .eoc (eoc_v[2]),
        .numero (numero_c), .out (out_v[2]), .underrun (und_v[2])
    );

    // Converter model: eoc falls one clock after soc=1 is seen, rises two clocks later.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                eoc_v[i]  <= idle_lvl[i];
                busy_m[i] <= 1'b0;
                tmr_m[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!busy_m[i] && soc_v[i]) begin
                    busy_m[i] <= 1'b1;
                    tmr_m[i]  <= 2;
                    eoc_v[i]  <= 1'b0;
                end else if (busy_m[i]) begin
                    if (tmr_m[i] == 1) begin
                        busy_m[i] <= 1'b0;
                        eoc_v[i]  <= 1'b1;
                    end else begin
                        tmr_m[i] <= tmr_m[i] - 1;
                    end
                end else begin
                    eoc_v[i] <= idle_lvl[i];
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cur);
        end
    endtask

    task automatic step_to(input int target);
        while (cur < target) begin
            @(posedge clock);
            cur++;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cur = 0;
    endtask

    initial begin
        idle_lvl = 3'b111;
        numero_a = 8'd8;
        numero_b = 4'd0;
        numero_c = 8'd8;

        // Run 1: nominal W=8, INIT=10, numero=8
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_val("rst_soc", soc_v[0], 1'b0);
        check_val("rst_out", out_v[0], 1'b0);
        check_val("rst_und", und_v[0], 1'b0);
        @(negedge clock);
        reset = 1'b0;
        cur = 0;
        step_to(1);  check_val("n_soc_e1", soc_v[0], 1'b1);
        step_to(2);  check_val("n_soc_e2", soc_v[0], 1'b1);
        step_to(3);  check_val("n_soc_e3", soc_v[0], 1'b0);
        step_to(9);  check_val("n_out_e9", out_v[0], 1'b0);
        step_to(10); check_val("n_out_e10", out_v[0], 1'b1);
                     check_val("n_soc_e10", soc_v[0], 1'b0);
        step_to(11); check_val("n_soc_e11", soc_v[0], 1'b1);
        step_to(17); check_val("n_out_e17", out_v[0], 1'b1);
        step_to(18); check_val("n_out_e18", out_v[0], 1'b0);
        step_to(25); check_val("n_out_e25", out_v[0], 1'b0);
        step_to(26); check_val("n_out_e26", out_v[0], 1'b1);
                     check_val("n_und_e26", und_v[0], 1'b0);

        // Run 2: numero=2 starves the counter
        numero_a = 8'd2;
        do_reset();
        step_to(10); check_val("u_out_e10", out_v[0], 1'b1);
        step_to(11); check_val("u_und_e11", und_v[0], 1'b0);
        step_to(12); check_val("u_und_e12", und_v[0], 1'b1);
        step_to(15); check_val("u_out_e15", out_v[0], 1'b1);
        step_to(16); check_val("u_out_e16", out_v[0], 1'b0);
        step_to(21); check_val("u_out_e21", out_v[0], 1'b0);
        step_to(22); check_val("u_out_e22", out_v[0], 1'b1);
                     check_val("u_und_e22", und_v[0], 1'b1);

        // Run 2b: async reset pulse while in F_CONV (edge 13 of a numero=2 run)
        numero_a = 8'd2;
        do_reset();
        step_to(13);
        check_val("r_out_pre", out_v[0], 1'b1);
        check_val("r_und_pre", und_v[0], 1'b1);
        #2;
        reset = 1'b1;
        numero_a = 8'd8;
        #1;
        check_val("r_out_async", out_v[0], 1'b0);
        check_val("r_und_async", und_v[0], 1'b0);
        check_val("r_soc_async", soc_v[0], 1'b0);
        #1;
        reset = 1'b0;
        cur = 0;
        step_to(1);  check_val("r_soc_e1", soc_v[0], 1'b1);
        step_to(3);  check_val("r_soc_e3", soc_v[0], 1'b0);
        step_to(9);  check_val("r_out_e9", out_v[0], 1'b0);
        step_to(10); check_val("r_out_e10", out_v[0], 1'b1);
        step_to(12); check_val("r_und_e12", und_v[0], 1'b0);

        // Run 3: eoc already low when soc rises
        idle_lvl[0] = 1'b0;
        numero_a = 8'd8;
        do_reset();
        step_to(1);  check_val("l_soc_e1", soc_v[0], 1'b1);
        step_to(2);  check_val("l_soc_e2", soc_v[0], 1'b0);
        step_to(9);  check_val("l_out_e9", out_v[0], 1'b0);
        step_to(10); check_val("l_out_e10", out_v[0], 1'b1);
        step_to(11); check_val("l_soc_e11", soc_v[0], 1'b1);
        idle_lvl[0] = 1'b1;

        // Run 4: W=4 with zero samples (b), INIT=1 (c)
        do_reset();
        step_to(1);  check_val("c_und_e1", und_v[2], 1'b1);
        step_to(5);  check_val("c_out_e5", out_v[2], 1'b0);
        step_to(6);  check_val("c_out_e6", out_v[2], 1'b1);
        step_to(7);  check_val("c_soc_e7", soc_v[2], 1'b1);
        step_to(9);  check_val("b_out_e9", out_v[1], 1'b0);
        step_to(10); check_val("b_out_e10", out_v[1], 1'b1);
        step_to(13); check_val("c_out_e13", out_v[2], 1'b1);
        step_to(14); check_val("c_out_e14", out_v[2], 1'b0);
        step_to(25); check_val("b_out_e25", out_v[1], 1'b1);
        step_to(26); check_val("b_out_e26", out_v[1], 1'b0);
        step_to(41); check_val("b_out_e41", out_v[1], 1'b0);
        step_to(42); check_val("b_out_e42", out_v[1], 1'b1);
                     check_val("b_und_e42", und_v[1], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
